// File: rtl/alu_muldiv_ctrl_if.sv
// EX-stage ALU control / mult-div sequencer signal bundle.
// master = pipeline side, slave = alu_muldiv_ctrl.
interface alu_muldiv_ctrl_if #(
    parameter int WIDTH = 32
);
    logic [5:0]       instruction_funct;
    logic [1:0]       alu_op_ctrl;
    logic             issue_valid;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic [3:0]       alu_ctrl;
    logic             md_busy;
    logic             stall;
    logic [WIDTH-1:0] hilo_rd_data;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output instruction_funct, alu_op_ctrl, issue_valid, operand_a, operand_b,
        input  alu_ctrl, md_busy, stall, hilo_rd_data, hi, lo
    );

    modport slave (
        input  instruction_funct, alu_op_ctrl, issue_valid, operand_a, operand_b,
        output alu_ctrl, md_busy, stall, hilo_rd_data, hi, lo
    );
endinterface

// File: rtl/alu_muldiv_ctrl.sv
// ALU control decode plus iterative mult/div sequencer with HI/LO registers.
// Optional: define MULDIV_EARLY_TERM_EN to end MUL once the remaining multiplier bits are zero.
module alu_muldiv_ctrl #(
    parameter int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_muldiv_ctrl_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_MUL   = 2'd1;
    localparam logic [1:0] S_DIV   = 2'd2;
    localparam logic [1:0] S_FIXUP = 2'd3;

    localparam logic [5:0] F_MFHI = 6'b010000;
    localparam logic [5:0] F_MTHI = 6'b010001;
    localparam logic [5:0] F_MTLO = 6'b010011;

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   raw_a;
    logic               neg_res, neg_rem, is_div, div_zero;
    logic [WIDTH-1:0]   hi_q, lo_q;

    logic [5:0]         funct;
    logic               rtype, md_class, start_op, accept, mt_hi, mt_lo;
    logic               a_neg, b_neg, mul_last;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [2*WIDTH-1:0] mul_sum, div_next, prod;
    logic [WIDTH:0]     div_shift, div_trial;
    logic [WIDTH-1:0]   fix_quo, fix_rem;

    assign funct    = bus.instruction_funct;
    assign rtype    = (bus.alu_op_ctrl == 2'b10);
    assign start_op = rtype & (funct[5:2] == 4'b0110);
    assign md_class = start_op | (rtype & (funct[5:2] == 4'b0100));
    assign accept   = bus.issue_valid & start_op & (state == S_IDLE);
    assign mt_hi    = bus.issue_valid & ~bus.stall & rtype & (funct == F_MTHI);
    assign mt_lo    = bus.issue_valid & ~bus.stall & rtype & (funct == F_MTLO);

    // even functs (MULT/DIV) are the signed variants
    assign a_neg = ~funct[0] & bus.operand_a[WIDTH-1];
    assign b_neg = ~funct[0] & bus.operand_b[WIDTH-1];
    assign abs_a = a_neg ? -bus.operand_a : bus.operand_a;
    assign abs_b = b_neg ? -bus.operand_b : bus.operand_b;

    assign mul_sum   = acc + (mplier[0] ? mcand : '0);
    assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, mcand[WIDTH-1:0]};
    // remainder lives in acc's upper half, dividend shifts out / quotient shifts into the lower half
    assign div_next  = div_trial[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                        : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    assign prod    = neg_res ? -acc : acc;
    assign fix_quo = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign fix_rem = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

`ifdef MULDIV_EARLY_TERM_EN
    assign mul_last = (cnt == CNT_W'(1)) | (mplier[WIDTH-1:1] == '0);
`else
    assign mul_last = (cnt == CNT_W'(1));
`endif

    always_comb begin
        bus.alu_ctrl = 4'b0010;
        case (bus.alu_op_ctrl)
            2'b01: bus.alu_ctrl = 4'b0110;
            2'b10: begin
                case (funct)
                    6'b100010: bus.alu_ctrl = 4'b0110;
                    6'b100100: bus.alu_ctrl = 4'b0000;
                    6'b100101: bus.alu_ctrl = 4'b0001;
                    6'b101010: bus.alu_ctrl = 4'b0111;
                    6'b100111: bus.alu_ctrl = 4'b1100;
                    default:   bus.alu_ctrl = 4'b0010;
                endcase
            end
            default: bus.alu_ctrl = 4'b0010;
        endcase
    end

    assign bus.md_busy      = (state != S_IDLE);
    assign bus.stall        = bus.issue_valid & md_class & (state != S_IDLE);
    assign bus.hilo_rd_data = (rtype & (funct == F_MFHI)) ? hi_q : lo_q;
    assign bus.hi           = hi_q;
    assign bus.lo           = lo_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            raw_a    <= '0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            is_div   <= 1'b0;
            div_zero <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        cnt      <= CNT_W'(WIDTH);
                        raw_a    <= bus.operand_a;
                        div_zero <= (bus.operand_b == '0);
                        neg_res  <= a_neg ^ b_neg;
                        neg_rem  <= a_neg;
                        is_div   <= funct[1];
                        if (funct[1]) begin
                            acc   <= {{WIDTH{1'b0}}, abs_a};
                            mcand <= {{WIDTH{1'b0}}, abs_b};
                            state <= S_DIV;
                        end else begin
                            acc    <= '0;
                            mcand  <= {{WIDTH{1'b0}}, abs_a};
                            mplier <= abs_b;
                            state  <= S_MUL;
                        end
                    end
                end
                S_MUL: begin
                    acc    <= mul_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - CNT_W'(1);
                    if (mul_last) state <= S_FIXUP;
                end
                S_DIV: begin
                    acc <= div_next;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) state <= S_FIXUP;
                end
                S_FIXUP: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                    if (!is_div) begin
                        {hi_q, lo_q} <= prod;
                    end else if (div_zero) begin
                        hi_q <= raw_a;
                        lo_q <= '1;
                    end else begin
                        hi_q <= fix_rem;
                        lo_q <= fix_quo;
                    end
                end
                default: state <= S_IDLE;
            endcase
            // MTHI/MTLO are stalled while busy, so they never collide with FIXUP
            if (mt_hi) hi_q <= bus.operand_a;
            if (mt_lo) lo_q <= bus.operand_a;
        end
    end
endmodule

// File: tb/tb_alu_muldiv_ctrl.sv
// Directed self-checking bench for alu_muldiv_ctrl (32-bit).
module tb_alu_muldiv_ctrl;
`ifdef MULDIV_EARLY_TERM_EN
    localparam bit ET = 1'b1;
`else
    localparam bit ET = 1'b0;
`endif

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_ADD   = 6'b100000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   k;

    always #5 clk = ~clk;

    alu_muldiv_ctrl_if #(.WIDTH(32)) bus ();

    alu_muldiv_ctrl #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] f,
                         input logic [31:0] a, input logic [31:0] b);
        bus.issue_valid       = v;
        bus.alu_op_ctrl       = op;
        bus.instruction_funct = f;
        bus.operand_a         = a;
        bus.operand_b         = b;
    endtask

    task automatic run_md(input string tag, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input int exp_busy);
        int n;
        drive(1'b1, 2'b10, f, a, b);
        tick();
        drive(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
        n = 0;
        while (bus.md_busy && n < 200) begin
            n++;
            tick();
        end
        chk({tag, "_busy"}, 64'(n), 64'(exp_busy));
        chk({tag, "_hi"}, 64'(bus.hi), 64'(exp_hi));
        chk({tag, "_lo"}, 64'(bus.lo), 64'(exp_lo));
    endtask

    logic [5:0] dec_f [7] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                              6'b101010, 6'b100111, 6'b111111};
    logic [3:0] dec_e [7] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001,
                              4'b0111, 4'b1100, 4'b0010};
    logic [1:0] cls_op [3] = '{2'b00, 2'b01, 2'b11};
    logic [3:0] cls_e  [3] = '{4'b0010, 4'b0110, 4'b0010};

    initial begin
        drive(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
        #3;
        chk("rst_busy", 64'(bus.md_busy), 64'd0);
        chk("rst_hi", 64'(bus.hi), 64'd0);
        chk("rst_lo", 64'(bus.lo), 64'd0);
        chk("rst_stall", 64'(bus.stall), 64'd0);
        #9 rst_n = 1'b1;
        tick();

        // decode sweep
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 2'b10, dec_f[i], 32'd0, 32'd0);
            #1;
            chk($sformatf("dec_f%0d", i), 64'(bus.alu_ctrl), 64'(dec_e[i]));
            chk($sformatf("dec_stall%0d", i), 64'(bus.stall), 64'd0);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, cls_op[i], 6'b111111, 32'd0, 32'd0);
            #1;
            chk($sformatf("dec_op%0d", i), 64'(bus.alu_ctrl), 64'(cls_e[i]));
        end
        drive(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
        tick();

        // multiply
        run_md("mult_n2x3", F_MULT, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, ET ? 3 : 33);
        run_md("multu_n2x3", F_MULTU, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA, ET ? 3 : 33);
        run_md("mult_3xn2", F_MULT, 32'd3, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFA, ET ? 3 : 33);
        run_md("mult_n1xn1", F_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, ET ? 2 : 33);

        // divide
        run_md("div_n7_2", F_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33);
        run_md("div_7_n2", F_DIV, 32'd7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD, 33);
        run_md("divu_7_0", F_DIVU, 32'd7, 32'd0, 32'h7, 32'hFFFFFFFF, 33);
        run_md("div_n5_0", F_DIV, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, 33);
        run_md("div_ovf", F_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 33);

        // MFLO stalls behind a running MULT; ADD flows through
        drive(1'b1, 2'b10, F_MULT, 32'd5, 32'd7);
        tick();
        drive(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
        tick();
        drive(1'b1, 2'b10, F_ADD, 32'd1, 32'd2);
        #1;
        chk("add_stall", 64'(bus.stall), 64'd0);
        chk("add_ctrl", 64'(bus.alu_ctrl), 64'b0010);
        chk("add_busy", 64'(bus.md_busy), 64'd1);
        tick();
        drive(1'b1, 2'b10, F_MFLO, 32'd0, 32'd0);
        #1;
        chk("mflo_stall", 64'(bus.stall), 64'd1);
        k = 2;
        while (bus.stall && k < 200) begin
            tick();
            k++;
        end
        chk("mflo_release", 64'(k), 64'(ET ? 4 : 33));
        chk("mflo_busy", 64'(bus.md_busy), 64'd0);
        chk("mflo_data", 64'(bus.hilo_rd_data), 64'd35);
        drive(1'b1, 2'b10, F_MFHI, 32'd0, 32'd0);
        #1;
        chk("mfhi_data", 64'(bus.hilo_rd_data), 64'd0);
        drive(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
        tick();

        // MTHI in idle, MTLO stalled behind MULTU then applied
        drive(1'b1, 2'b10, F_MTHI, 32'h12345678, 32'd0);
        tick();
        chk("mthi", 64'(bus.hi), 64'h12345678);
        drive(1'b1, 2'b10, F_MULTU, 32'd3, 32'd4);
        tick();
        drive(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
        tick();
        drive(1'b1, 2'b10, F_MTLO, 32'hAAAA5555, 32'd0);
        #1;
        chk("mtlo_stall", 64'(bus.stall), 64'd1);
        k = 1;
        while (bus.stall && k < 200) begin
            tick();
            k++;
        end
        chk("mtlo_release", 64'(k), 64'(ET ? 4 : 33));
        chk("mtlo_pre_lo", 64'(bus.lo), 64'd12);
        chk("mtlo_pre_hi", 64'(bus.hi), 64'd0);
        tick();
        chk("mtlo_lo", 64'(bus.lo), 64'hAAAA5555);
        chk("mtlo_hi", 64'(bus.hi), 64'd0);
        drive(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
        tick();

        // async reset aborts a running DIVU
        drive(1'b1, 2'b10, F_DIVU, 32'd100, 32'd7);
        tick();
        drive(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
        repeat (9) tick();
        chk("abort_pre_busy", 64'(bus.md_busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(bus.md_busy), 64'd0);
        chk("abort_hi", 64'(bus.hi), 64'd0);
        chk("abort_lo", 64'(bus.lo), 64'd0);
        #2 rst_n = 1'b1;
        tick();
        chk("abort_post_busy", 64'(bus.md_busy), 64'd0);
        run_md("divu_100_7", F_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 33);

        // multiplier-magnitude boundaries (early termination when enabled)
        run_md("multu_bx1", F_MULTU, 32'h00001234, 32'd1, 32'd0, 32'h00001234, ET ? 2 : 33);
        run_md("multu_bx0", F_MULTU, 32'h0000DEAD, 32'd0, 32'd0, 32'd0, ET ? 2 : 33);
        run_md("multu_msb", F_MULTU, 32'd1, 32'h80000000, 32'd0, 32'h80000000, 33);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
